shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares the single combinational barrel shifter (`ALU_shift`) between two requesters: port 0 is the EX stage and port 1 is the multi-cycle/auxiliary unit. The block accepts shift requests over a req/gnt handshake and arbitrates between them round-robin. It latches operands, drives the shifter from registered inputs, and returns a registered result with a one-cycle done pulse to the owning port.

## Interface
- No parameters. Data width is fixed at 32 and shamt width at 5.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  shift request, per port
- fun0 / fun1  in  6  ALUFun code, per port
- a0 / a1  in  5  shift amount, per port
- b0 / b1  in  32  operand to shift, per port
- gnt0 / gnt1  out  1  request accepted this cycle, per port
- done0 / done1  out  1  result valid this cycle, per port
- result  out  32  shared result bus, valid only while done0 or done1 is high
- err  out  1  asserted together with done when the latched fun is not a shift code

## Operation
- Shift codes:
  - 6'b100000 = SLL: b << a.
  - 6'b100001 = SRL: logical right shift.
  - 6'b100011 = SRA: arithmetic right shift, fills with b[31].
  - Any other code gives result = 0 and err = 1.
- Only a[4:0] is significant. A shift by 0 returns b unchanged.
- FSM states: IDLE, EXEC, DONE.
  - IDLE:
    - If any req is high, grant one port and latch its fun/a/b into operand registers, then go to EXEC.
    - If no req is high, stay in IDLE.
  - EXEC: the shifter sees only the operand registers. Capture the shifter output into the result register and the error flag into the err register, then go to DONE.
  - DONE: assert done for the owner port, then go to IDLE.
- gnt is combinational from req, the state, and the priority pointer. It is high only in IDLE, only for one port, and for exactly one cycle per accepted request.
- Arbitration:
  - The priority pointer `last` holds the last-served port and resets to 1, so port 0 wins the first tie.
  - When both ports request, grant the port not equal to `last`.
  - When one port requests, grant it.
  - Update `last` on every grant.
- Requester rules:
  - Hold req, fun, a and b stable until gnt is seen.
  - Dropping req before gnt withdraws the request with no side effects.
  - A port may re-request in the cycle after its done.
- The owner tag is registered at grant. done and err are routed only to the owner.

## Timing
- Reset values:
  - State = IDLE, last = 1.
  - gnt0 = gnt1 = 0 while no req is high.
  - done0 = done1 = 0, err = 0, result = 32'h0.
  - Operand registers are 0.
- Latency: with the grant edge as E0, the result is captured at E1 and done is high in the cycle between E1 and E2. That gives 2 cycles from grant to done.
- Throughput: one operation per 3 cycles. No grant is issued in EXEC or DONE; requests there simply wait.
- result and err hold their values after DONE until the next capture. Consumers must qualify them with done.
- Reset asserted in EXEC or DONE:
  - Return to IDLE immediately.
  - No done is issued for the in-flight operation.
  - result clears to 0 and last returns to 1.
- If req is high in the same cycle reset is released, it may be granted on the first edge after release.

## Structure
- Shared header (included by ALU, control and this block): ALUFun codes ALU_SLL, ALU_SRL and ALU_SRA; FSM state encodings S_IDLE, S_EXEC and S_DONE.
- The existing `ALU_shift` is instantiated unmodified as the single sub-module. Its A input gets {27'b0, shamt_q}, its B input gets b_q, and its ALUFun input gets fun_q.
- Arbitration and the FSM live in the top level. No other sub-modules.

## Test plan
- Port 0 only, fun=100000, a=4, b=32'hFFFFFFFF → gnt0 for 1 cycle, then done0 2 cycles later with result=32'hFFFFFFF0 and err=0. done1 stays 0.
- Port 1, fun=100001, a=4, b=32'hFFFFFFFF → result=32'h0FFFFFFF on done1. Repeat with fun=100011: b=32'hFFFFFFFF → 32'hFFFFFFFF, and b=32'h7FFFFFFF → 32'h07FFFFFF.
- Both ports request continuously after reset → grants alternate 0, 1, 0, 1 with one grant every 3 cycles, and each done goes to the matching port.
- fun=6'b000000 with b=32'h12345678 → done with result=0 and err=1. A following valid request gives err=0.
- Reset pulsed while in EXEC → no done, all outputs at reset values. The next request is served normally with port 0 winning a tie.
- req0 raised and dropped during another port's EXEC → no gnt0 and no done0 for the withdrawn request.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared ALU function codes and arbiter FSM encodings.
// Included by the ALU, control and the shift arbiter.
package shift_arbiter_pkg;

  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [5:0] f);
    return (f == ALU_SLL) || (f == ALU_SRL) || (f == ALU_SRA);
  endfunction

endpackage

// File: rtl/shift_arbiter_alu_shift.sv
// Combinational barrel shifter: SLL/SRL/SRA of B by A[4:0].
// Any other function code produces zero.
module ALU_shift
  import shift_arbiter_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALUFun,
  output logic [31:0] S
);

  // Only the low five bits of A select the shift distance.
  logic w_unused_hi;
  assign w_unused_hi = |A[31:5];

  always_comb begin
    S = 32'h0;
    case (ALUFun)
      ALU_SLL: S = B << A[4:0];
      ALU_SRL: S = B >> A[4:0];
      ALU_SRA: S = $unsigned($signed(B) >>> A[4:0]);
      default: S = 32'h0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between EX (port 0)
// and the auxiliary unit (port 1); registered operands, result and done.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [5:0]  fun0,
  input  logic [5:0]  fun1,
  input  logic [4:0]  a0,
  input  logic [4:0]  a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        err
);

  state_t      r_state;
  logic        r_last;
  logic        r_owner;
  logic [5:0]  r_fun;
  logic [4:0]  r_shamt;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_err;
  logic        r_done0;
  logic        r_done1;

  logic        w_gnt0;
  logic        w_gnt1;
  logic [31:0] w_shift;

  // On a tie the port that was not served last wins.
  assign w_gnt0 = (r_state == S_IDLE) && req0 && (!req1 || r_last);
  assign w_gnt1 = (r_state == S_IDLE) && req1 && (!req0 || !r_last);

  ALU_shift u_alu_shift (
    .A      ({27'b0, r_shamt}),
    .B      (r_b),
    .ALUFun (r_fun),
    .S      (w_shift)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_fun    <= 6'h0;
      r_shamt  <= 5'h0;
      r_b      <= 32'h0;
      r_result <= 32'h0;
      r_err    <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_owner <= w_gnt1;
            r_last  <= w_gnt1;
            r_fun   <= w_gnt1 ? fun1 : fun0;
            r_shamt <= w_gnt1 ? a1 : a0;
            r_b     <= w_gnt1 ? b1 : b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_shift;
          r_err    <= !is_shift(r_fun);
          r_done0  <= !r_owner;
          r_done1  <= r_owner;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0   = w_gnt0;
  assign gnt1   = w_gnt1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign result = r_result;
  assign err    = r_err;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: expected results queued at grant,
// popped and compared when done arrives.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [5:0]  fun0 = '0, fun1 = '0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] b0 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, err;
  logic [31:0] result;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  shift_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .fun0   (fun0),
    .fun1   (fun1),
    .a0     (a0),
    .a1     (a1),
    .b0     (b0),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic r, input logic [5:0] f,
                       input logic [4:0] a, input logic [31:0] b);
    if (p) begin
      req1 = r; fun1 = f; a1 = a; b1 = b;
    end else begin
      req0 = r; fun0 = f; a0 = a; b0 = b;
    end
  endtask

  task automatic wait_gnt(input logic p, output logic ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if ((p ? gnt1 : gnt0) === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_any(output logic ok, output int at, output logic gp);
    ok = 1'b0;
    at = 0;
    gp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if ((gnt0 | gnt1) === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        gp = gnt1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output logic ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 8; i++) begin
      if ((done0 | done1) === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_done_port"}, {30'b0, done1, done0}, e.port ? 32'd2 : 32'd1);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_err"}, {31'b0, err}, {31'b0, e.e});
    end
  endtask

  function automatic logic [31:0] model_res(input logic [5:0] f, input logic [4:0] a,
                                            input logic [31:0] b);
    case (f)
      6'b100000: return b << a;
      6'b100001: return b >> a;
      6'b100011: return $unsigned($signed(b) >>> a);
      default:   return 32'h0;
    endcase
  endfunction

  task automatic serve(input logic p, input logic [5:0] f, input logic [4:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ee,
                       input string tag);
    logic ok, okd;
    int   tg, td;
    @(negedge clk);
    drive(p, 1'b1, f, a, b);
    wait_gnt(p, ok, tg);
    chk({tag, "_gnt"}, {31'b0, ok}, 32'd1);
    chk({tag, "_gnt_excl"}, {31'b0, p ? gnt0 : gnt1}, 32'd0);
    if (ok) sb.push_back(exp_t'{p, er, ee});
    @(negedge clk);
    drive(p, 1'b0, f, a, b);
    #1;
    chk({tag, "_gnt_one_cycle"}, {30'b0, gnt0, gnt1}, 32'd0);
    wait_done(okd, td);
    chk({tag, "_done_seen"}, {31'b0, okd}, 32'd1);
    if (okd) begin
      chk({tag, "_latency"}, 32'(td - tg), 32'd2);
      pop_check(tag);
    end
    @(negedge clk);
    #1;
    chk({tag, "_done_clear"}, {30'b0, done0, done1}, 32'd0);
    chk({tag, "_result_hold"}, result, er);
  endtask

  initial begin
    logic ok, gp;
    int   tg, td, prev, cnt;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_gnt", {30'b0, gnt0, gnt1}, 32'd0);
    chk("rst_done", {30'b0, done0, done1}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single-port shifts
    serve(1'b0, 6'b100000, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFF0, 1'b0, "sll_p0");
    serve(1'b1, 6'b100001, 5'd4, 32'hFFFFFFFF, 32'h0FFFFFFF, 1'b0, "srl_p1");
    serve(1'b1, 6'b100011, 5'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "sra_neg");
    serve(1'b1, 6'b100011, 5'd4, 32'h7FFFFFFF, 32'h07FFFFFF, 1'b0, "sra_pos");
    serve(1'b1, 6'b100001, 5'd31, 32'h80000000, 32'h00000001, 1'b0, "srl_31");
    serve(1'b0, 6'b000000, 5'd4, 32'h12345678, 32'h00000000, 1'b1, "bad_fun");
    serve(1'b0, 6'b100000, 5'd0, 32'h12345678, 32'h12345678, 1'b0, "shift0");

    // Withdrawn request from port 0 during port 1's operation
    @(negedge clk);
    drive(1'b1, 1'b1, 6'b100000, 5'd8, 32'h000000AB);
    wait_gnt(1'b1, ok, tg);
    chk("wd_gnt1", {31'b0, ok}, 32'd1);
    if (ok) sb.push_back(exp_t'{1'b1, 32'h0000AB00, 1'b0});
    @(negedge clk);
    drive(1'b1, 1'b0, 6'b100000, 5'd8, 32'h000000AB);
    drive(1'b0, 1'b1, 6'b100000, 5'd1, 32'h00000005);
    #1;
    chk("wd_no_gnt0_exec", {31'b0, gnt0}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 6'b100000, 5'd1, 32'h00000005);
    #1;
    wait_done(ok, td);
    chk("wd_done1_seen", {31'b0, ok}, 32'd1);
    if (ok) pop_check("wd");
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (gnt0 === 1'b1 || done0 === 1'b1) cnt++;
    end
    chk("wd_no_gnt0_done0", 32'(cnt), 32'd0);

    // Reset during EXEC: port 0 is served first so a tie would go to port 1 without reset
    @(negedge clk);
    drive(1'b0, 1'b1, 6'b100001, 5'd2, 32'h00000010);
    wait_gnt(1'b0, ok, tg);
    chk("rx_gnt0", {31'b0, ok}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 6'b100001, 5'd2, 32'h00000010);
    reset = 1'b1;
    #1;
    chk("rx_done", {30'b0, done0, done1}, 32'd0);
    chk("rx_result", result, 32'h0);
    chk("rx_err", {31'b0, err}, 32'd0);
    chk("rx_gnt", {30'b0, gnt0, gnt1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done0 === 1'b1 || done1 === 1'b1) cnt++;
    end
    chk("rx_no_done", 32'(cnt), 32'd0);

    // Tie after reset goes to port 0
    @(negedge clk);
    drive(1'b0, 1'b1, 6'b100000, 5'd3, 32'h00000001);
    drive(1'b1, 1'b1, 6'b100001, 5'd3, 32'h00000100);
    wait_any(ok, tg, gp);
    chk("tie_gnt", {31'b0, ok}, 32'd1);
    chk("tie_port", {31'b0, gp}, 32'd0);
    if (ok) sb.push_back(exp_t'{1'b0, 32'h00000008, 1'b0});
    @(negedge clk);
    drive(1'b0, 1'b0, 6'b100000, 5'd3, 32'h00000001);
    drive(1'b1, 1'b0, 6'b100001, 5'd3, 32'h00000100);
    #1;
    wait_done(ok, td);
    chk("tie_done_seen", {31'b0, ok}, 32'd1);
    if (ok) pop_check("tie");

    // Continuous requests from both ports alternate, one grant per 3 cycles
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 6'b100000, 5'd1, 32'h00000001);
    drive(1'b1, 1'b1, 6'b100001, 5'd1, 32'h00000080);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any(ok, tg, gp);
      chk("alt_gnt", {31'b0, ok}, 32'd1);
      if (!ok) break;
      chk("alt_port", {31'b0, gp}, 32'(k % 2));
      chk("alt_excl", {31'b0, gnt0 & gnt1}, 32'd0);
      if (k > 0) chk("alt_gap", 32'(tg - prev), 32'd3);
      prev = tg;
      sb.push_back(exp_t'{gp, gp ? model_res(fun1, a1, b1) : model_res(fun0, a0, b0), 1'b0});
      @(negedge clk);
      #1;
      wait_done(ok, td);
      chk("alt_done_seen", {31'b0, ok}, 32'd1);
      if (ok) pop_check("alt");
    end
    drive(1'b0, 1'b0, 6'b100000, 5'd1, 32'h00000001);
    drive(1'b1, 1'b0, 6'b100001, 5'd1, 32'h00000080);
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
